// File: rtl/ped_if.sv
// Signal bundle between the vehicle-light side and the pedestrian crossing controller.
// The controller takes the slave modport; whatever drives light/button takes the master side.
interface ped_if #(
  parameter int CNT_W = 4
);
  logic [2:0]       light;
  logic             ped_button;
  logic             walk;
  logic             dont_walk;
  logic [CNT_W-1:0] countdown;
  logic             req_pending;
  logic             light_err;
  logic [1:0]       state_dbg;

  modport master (
    output light, ped_button,
    input  walk, dont_walk, countdown, req_pending, light_err, state_dbg
  );

  modport slave (
    input  light, ped_button,
    output walk, dont_walk, countdown, req_pending, light_err, state_dbg
  );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: grants WALK only during vehicle red, then flashes DON'T WALK,
// and falls back to steady DON'T WALK whenever red is lost. All outputs come straight from flops.
module ped_crossing_ctrl #(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 4,
  parameter int CNT_W        = 4
) (
  input  logic clock,
  input  logic reset_n,
  ped_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WALK       = 2'd1,
    S_FLASH      = 2'd2,
    S_WAIT_CLEAR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  state_t           state_q, state_d;
  logic             walk_q, walk_d;
  logic             dont_walk_q, dont_walk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             err_q, err_d;
  logic             is_red;
  logic             is_legal;

  always_comb begin
    is_red      = (bus.light == 3'b100);
    is_legal    = is_red || (bus.light == 3'b010) || (bus.light == 3'b001);
    state_d     = state_q;
    walk_d      = walk_q;
    dont_walk_d = dont_walk_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    err_d       = !is_legal;

    unique case (state_q)
      S_IDLE: begin
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        cnt_d       = CNT_ZERO;
        if ((req_q || bus.ped_button) && is_red) begin
          // Entering WALK serves the request; this clear beats a same-edge press.
          state_d     = S_WALK;
          walk_d      = 1'b1;
          dont_walk_d = 1'b0;
          cnt_d       = WALK_LOAD;
          req_d       = 1'b0;
        end else if (bus.ped_button) begin
          req_d = 1'b1;
        end
      end

      S_WALK: begin
        if (!is_red) begin
          // Interrupted walk: remember the pedestrian so the next red re-serves them.
          state_d     = S_IDLE;
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
          cnt_d       = CNT_ZERO;
          req_d       = 1'b1;
        end else if (cnt_q == CNT_ZERO) begin
          state_d     = S_FLASH;
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
          cnt_d       = FLASH_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FLASH: begin
        if (bus.ped_button) begin
          req_d = 1'b1;
        end
        if (!is_red) begin
          state_d     = S_IDLE;
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
          cnt_d       = CNT_ZERO;
        end else if (cnt_q == CNT_ZERO) begin
          state_d     = S_WAIT_CLEAR;
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
          cnt_d       = CNT_ZERO;
        end else begin
          dont_walk_d = !dont_walk_q;
          cnt_d       = cnt_q - 1'b1;
        end
      end

      S_WAIT_CLEAR: begin
        // Hold off until red ends so a single red phase is never served twice.
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        cnt_d       = CNT_ZERO;
        if (bus.ped_button) begin
          req_d = 1'b1;
        end
        if (!is_red) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        cnt_d       = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      cnt_q       <= CNT_ZERO;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      err_q       <= err_d;
    end
  end

  assign bus.walk        = walk_q;
  assign bus.dont_walk   = dont_walk_q;
  assign bus.countdown   = cnt_q;
  assign bus.req_pending = req_q;
  assign bus.light_err   = err_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed walk-through of the crossing scenarios with literal
// expectations, then randomized light/button traffic compared every cycle against a phase model.
module tb_ped_crossing_ctrl;

  localparam int WALK_CYCLES  = 8;
  localparam int FLASH_CYCLES = 4;
  localparam int CNT_W        = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_WALK  = 1;
  localparam int PH_FLASH = 2;
  localparam int PH_CLEAR = 3;

  logic clock;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  ped_if #(.CNT_W(CNT_W)) bus ();

  ped_crossing_ctrl #(
    .WALK_CYCLES (WALK_CYCLES),
    .FLASH_CYCLES(FLASH_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Tracks which phase we are in and how many cycles of it have elapsed; outputs are derived.
  int m_phase   = PH_IDLE;
  int m_elapsed = 0;
  bit m_req     = 1'b0;
  bit m_err     = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase   = PH_IDLE;
      m_elapsed = 0;
      m_req     = 1'b0;
      m_err     = 1'b0;
    end else begin
      bit red;
      bit btn;
      red   = (bus.light == 3'b100);
      btn   = bus.ped_button;
      m_err = !(bus.light inside {3'b100, 3'b010, 3'b001});
      case (m_phase)
        PH_IDLE: begin
          if ((m_req || btn) && red) begin
            m_phase = PH_WALK; m_elapsed = 0; m_req = 1'b0;
          end else if (btn) begin
            m_req = 1'b1;
          end
        end
        PH_WALK: begin
          if (!red) begin
            m_phase = PH_IDLE; m_req = 1'b1;
          end else if (m_elapsed == WALK_CYCLES - 1) begin
            m_phase = PH_FLASH; m_elapsed = 0;
          end else begin
            m_elapsed++;
          end
        end
        PH_FLASH: begin
          if (btn) m_req = 1'b1;
          if (!red) m_phase = PH_IDLE;
          else if (m_elapsed == FLASH_CYCLES - 1) m_phase = PH_CLEAR;
          else m_elapsed++;
        end
        default: begin
          if (btn) m_req = 1'b1;
          if (!red) m_phase = PH_IDLE;
        end
      endcase
    end
  end

  function automatic int exp_walk();
    return (m_phase == PH_WALK) ? 1 : 0;
  endfunction

  function automatic int exp_dont_walk();
    if (m_phase == PH_WALK) return 0;
    if (m_phase == PH_FLASH) return (m_elapsed % 2 == 0) ? 1 : 0;
    return 1;
  endfunction

  function automatic int exp_countdown();
    if (m_phase == PH_WALK) return WALK_CYCLES - 1 - m_elapsed;
    if (m_phase == PH_FLASH) return FLASH_CYCLES - 1 - m_elapsed;
    return 0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("cyc_walk",      int'(bus.walk),        exp_walk());
    check("cyc_dont_walk", int'(bus.dont_walk),   exp_dont_walk());
    check("cyc_countdown", int'(bus.countdown),   exp_countdown());
    check("cyc_req",       int'(bus.req_pending), int'(m_req));
    check("cyc_light_err", int'(bus.light_err),   int'(m_err));
  end

  // ---------------- driver ----------------
  task automatic tick(input logic [2:0] l, input logic b);
    bus.light      = l;
    bus.ped_button = b;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input int w, input int dw, input int cnt,
                            input int req);
    check({name, "_walk"},      int'(bus.walk),        w);
    check({name, "_dont_walk"}, int'(bus.dont_walk),   dw);
    check({name, "_countdown"}, int'(bus.countdown),   cnt);
    check({name, "_req"},       int'(bus.req_pending), req);
  endtask

  initial begin
    logic [2:0] l;
    int         run;
    int         r;

    reset_n        = 1'b0;
    bus.light      = 3'b000;
    bus.ped_button = 1'b0;

    // Reset held while inputs wiggle.
    for (int i = 0; i < 4; i++) begin
      tick(3'($urandom_range(0, 7)), 1'(i % 2));
      expect_out("rst_hold", 0, 1, 0, 0);
      check("rst_hold_err", int'(bus.light_err), 0);
    end
    reset_n = 1'b1;
    tick(3'b100, 1'b0);
    expect_out("idle_red", 0, 1, 0, 0);

    // Nominal service.
    tick(3'b100, 1'b1);
    expect_out("nom_walk_entry", 1, 0, 7, 0);
    check("nom_state_walk", int'(bus.state_dbg), 1);
    for (int i = 6; i >= 0; i--) begin
      tick(3'b100, 1'b0);
      expect_out("nom_walk", 1, 0, i, 0);
    end
    for (int i = 3; i >= 0; i--) begin
      tick(3'b100, 1'b0);
      expect_out("nom_flash", 0, i % 2, i, 0);
    end
    tick(3'b100, 1'b0);
    expect_out("nom_clear", 0, 1, 0, 0);
    check("nom_state_clear", int'(bus.state_dbg), 3);
    tick(3'b100, 1'b0);
    check("nom_clear_hold", int'(bus.state_dbg), 3);
    tick(3'b010, 1'b0);
    expect_out("nom_idle", 0, 1, 0, 0);
    check("nom_state_idle", int'(bus.state_dbg), 0);

    // Request while not red.
    tick(3'b010, 1'b1);
    expect_out("req_green", 0, 1, 0, 1);
    tick(3'b100, 1'b0);
    expect_out("req_served", 1, 0, 7, 0);

    // Abort from WALK after three WALK cycles.
    tick(3'b100, 1'b0);
    tick(3'b100, 1'b0);
    tick(3'b001, 1'b0);
    expect_out("abort_walk", 0, 1, 0, 1);
    check("abort_state", int'(bus.state_dbg), 0);
    tick(3'b100, 1'b0);
    expect_out("abort_reserve", 1, 0, 7, 0);

    // No double service within one red phase.
    for (int i = 0; i < 8; i++) tick(3'b100, 1'b0);
    expect_out("nds_flash_entry", 0, 1, 3, 0);
    tick(3'b100, 1'b1);
    expect_out("nds_flash_press", 0, 0, 2, 1);
    for (int i = 0; i < 2; i++) tick(3'b100, 1'b0);
    tick(3'b100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(3'b100, 1'b0);
      expect_out("nds_hold_red", 0, 1, 0, 1);
    end
    tick(3'b010, 1'b0);
    check("nds_idle", int'(bus.state_dbg), 0);
    tick(3'b100, 1'b0);
    expect_out("nds_reserve", 1, 0, 7, 0);

    // Illegal codes.
    tick(3'b100, 1'b0);
    tick(3'b110, 1'b0);
    expect_out("ill_abort", 0, 1, 0, 1);
    check("ill_err_high", int'(bus.light_err), 1);
    tick(3'b010, 1'b0);
    check("ill_err_low", int'(bus.light_err), 0);
    tick(3'b000, 1'b0);
    check("ill_zero_err", int'(bus.light_err), 1);
    tick(3'b010, 1'b0);
    check("ill_zero_clr", int'(bus.light_err), 0);

    // Asynchronous reset mid-WALK.
    tick(3'b100, 1'b0);
    tick(3'b100, 1'b0);
    check("arst_in_walk", int'(bus.walk), 1);
    reset_n = 1'b0;
    #1;
    expect_out("arst", 0, 1, 0, 0);
    check("arst_err", int'(bus.light_err), 0);
    tick(3'b100, 1'b1);
    reset_n = 1'b1;

    // Randomized traffic checked by the per-cycle compare.
    for (int k = 0; k < 3000; ) begin
      r = $urandom_range(0, 9);
      if (r < 6)       l = 3'b100;
      else if (r < 8)  l = 3'b010;
      else if (r == 8) l = 3'b001;
      else             l = 3'($urandom_range(0, 7));
      run = $urandom_range(1, 24);
      for (int j = 0; j < run; j++) begin
        tick(l, ($urandom_range(0, 5) == 0));
        k++;
        if ($urandom_range(0, 799) == 0) begin
          reset_n = 1'b0;
          @(posedge clock);
          #1;
          reset_n = 1'b1;
        end
      end
    end

    tick(3'b010, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
